// File: rtl/stdout_uart_tx.sv
// STDOUT transmit path: byte FIFO feeding an 8N1 UART serializer (LSB first).
// Define STDOUT_UART_TX_PARITY_EN to insert an even-parity bit (8E1 framing).
module stdout_uart_tx #(
  parameter int CLK_PER_BIT = 868,
  parameter int FIFO_DEPTH  = 16
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       stdout_write_enable,
  input  logic [7:0] stdout_write_data,
  output logic       stdout_full,
  output logic       stdout_empty,
  output logic       stdout_overflow,
  output logic       txd
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int BW = $clog2(CLK_PER_BIT);

  localparam logic [AW:0]   FULL_COUNT = (AW+1)'(FIFO_DEPTH);
  localparam logic [AW:0]   CNT_ONE    = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE    = AW'(1);
  localparam logic [BW-1:0] BAUD_LAST  = BW'(CLK_PER_BIT - 1);
  localparam logic [BW-1:0] BAUD_ONE   = BW'(1);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
  localparam logic [2:0] STOP   = 3'd3;
`ifdef STDOUT_UART_TX_PARITY_EN
  localparam logic [2:0] PARITY = 3'd4;
`endif

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_reg;
  logic [AW-1:0] rd_ptr_reg;
  logic [AW:0]   count_reg;
  logic          overflow_reg;

  logic [2:0]    state_reg;
  logic [BW-1:0] baud_reg;
  logic [2:0]    bit_idx_reg;
  logic [7:0]    shift_reg;
  logic          txd_reg;
`ifdef STDOUT_UART_TX_PARITY_EN
  logic          parity_reg;
`endif

  logic full;
  logic push;
  logic pop;
  logic baud_done;
  logic have_data;

  assign full      = (count_reg == FULL_COUNT);
  assign have_data = (count_reg != '0);
  assign baud_done = (baud_reg == BAUD_LAST);
  assign push      = stdout_write_enable && !full;
  // Pop either from IDLE or at the tail of a stop bit, so frames run back to back.
  assign pop       = have_data && ((state_reg == IDLE) || (state_reg == STOP && baud_done));

  assign stdout_full     = full;
  assign stdout_empty    = !have_data && (state_reg == IDLE);
  assign stdout_overflow = overflow_reg;
  assign txd             = txd_reg;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_reg] <= stdout_write_data;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      overflow_reg <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
      end
      if (push && !pop) begin
        count_reg <= count_reg + CNT_ONE;
      end else if (pop && !push) begin
        count_reg <= count_reg - CNT_ONE;
      end
      // Full is judged on the registered count, so a same-cycle pop does not rescue the write.
      if (stdout_write_enable && full) begin
        overflow_reg <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_reg   <= IDLE;
      baud_reg    <= '0;
      bit_idx_reg <= '0;
      shift_reg   <= '0;
      txd_reg     <= 1'b1;
`ifdef STDOUT_UART_TX_PARITY_EN
      parity_reg  <= 1'b0;
`endif
    end else begin
      case (state_reg)
        IDLE: begin
          txd_reg <= 1'b1;
          if (pop) begin
            shift_reg <= mem[rd_ptr_reg];
`ifdef STDOUT_UART_TX_PARITY_EN
            parity_reg <= ^mem[rd_ptr_reg];
`endif
            baud_reg  <= '0;
            state_reg <= START;
            txd_reg   <= 1'b0;
          end
        end
        START: begin
          if (baud_done) begin
            baud_reg    <= '0;
            bit_idx_reg <= '0;
            state_reg   <= DATA;
            txd_reg     <= shift_reg[0];
          end else begin
            baud_reg <= baud_reg + BAUD_ONE;
          end
        end
        DATA: begin
          if (baud_done) begin
            baud_reg  <= '0;
            shift_reg <= {1'b0, shift_reg[7:1]};
            if (bit_idx_reg == 3'd7) begin
`ifdef STDOUT_UART_TX_PARITY_EN
              state_reg <= PARITY;
              txd_reg   <= parity_reg;
`else
              state_reg <= STOP;
              txd_reg   <= 1'b1;
`endif
            end else begin
              bit_idx_reg <= bit_idx_reg + 3'd1;
              txd_reg     <= shift_reg[1];
            end
          end else begin
            baud_reg <= baud_reg + BAUD_ONE;
          end
        end
`ifdef STDOUT_UART_TX_PARITY_EN
        PARITY: begin
          if (baud_done) begin
            baud_reg  <= '0;
            state_reg <= STOP;
            txd_reg   <= 1'b1;
          end else begin
            baud_reg <= baud_reg + BAUD_ONE;
          end
        end
`endif
        STOP: begin
          if (baud_done) begin
            baud_reg <= '0;
            if (pop) begin
              shift_reg <= mem[rd_ptr_reg];
`ifdef STDOUT_UART_TX_PARITY_EN
              parity_reg <= ^mem[rd_ptr_reg];
`endif
              state_reg <= START;
              txd_reg   <= 1'b0;
            end else begin
              state_reg <= IDLE;
              txd_reg   <= 1'b1;
            end
          end else begin
            baud_reg <= baud_reg + BAUD_ONE;
          end
        end
        default: begin
          state_reg <= IDLE;
          baud_reg  <= '0;
          txd_reg   <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_stdout_uart_tx.sv
// Directed bench for stdout_uart_tx: a txd frame decoder pops an expected-byte
// scoreboard filled as writes are driven; also checks timing, flags and reset.
module tb_stdout_uart_tx;

  localparam int CPB   = 4;
  localparam int DEPTH = 4;
`ifdef STDOUT_UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  localparam int FRAME = NB * CPB;

  logic       clk = 1'b0;
  logic       rstn;
  logic       stdout_write_enable;
  logic [7:0] stdout_write_data;
  logic       stdout_full;
  logic       stdout_empty;
  logic       stdout_overflow;
  logic       txd;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int frames_done = 0;
  int frames_aborted = 0;
  logic [7:0] sb [$];
  int starts [$];

  stdout_uart_tx #(.CLK_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .clk                 (clk),
    .rstn                (rstn),
    .stdout_write_enable (stdout_write_enable),
    .stdout_write_data   (stdout_write_data),
    .stdout_full         (stdout_full),
    .stdout_empty        (stdout_empty),
    .stdout_overflow     (stdout_overflow),
    .txd                 (txd)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One write sampled at the next rising edge; returns 1 time unit after it.
  task automatic drive(input logic [7:0] b, input bit accept);
    @(negedge clk);
    stdout_write_enable = 1'b1;
    stdout_write_data   = b;
    if (accept) sb.push_back(b);
    @(posedge clk);
    #1;
    stdout_write_enable = 1'b0;
  endtask

  task automatic wait_empty(output int n, input int limit);
    n = 0;
    while (stdout_empty !== 1'b1 && n < limit) begin
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rstn = 1'b0;
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // Frame decoder: samples every cycle on the falling edge so bit widths are checked exactly.
  initial begin : monitor
    logic [10:0] bits;
    bit aborted;
    bit bad_shape;
    int t0;
    logic [7:0] exp_byte;
    forever begin
      @(negedge clk);
      if (rstn === 1'b1 && txd === 1'b0) begin
        t0 = cyc;
        aborted = 1'b0;
        bad_shape = 1'b0;
        bits = '1;
        for (int b = 0; b < NB; b++) begin
          for (int s = 0; s < CPB; s++) begin
            if (b != 0 || s != 0) @(negedge clk);
            if (rstn !== 1'b1) begin
              aborted = 1'b1;
              break;
            end
            if (s == 0) bits[b] = txd;
            else if (txd !== bits[b]) bad_shape = 1'b1;
          end
          if (aborted) break;
        end
        if (aborted) begin
          frames_aborted++;
        end else begin
          frames_done++;
          starts.push_back(t0);
          $display("rx byte %02h start_cycle %0d", bits[8:1], t0);
          chk("bit_width", 32'(bad_shape), 32'(0));
          chk("stop_bit", 32'(bits[NB-1]), 32'(1));
          chk("frame_expected", 32'(sb.size() > 0), 32'(1));
          if (sb.size() > 0) begin
            exp_byte = sb.pop_front();
            chk("data_byte", 32'(bits[8:1]), 32'(exp_byte));
`ifdef STDOUT_UART_TX_PARITY_EN
            chk("parity_bit", 32'(bits[9]), 32'(^exp_byte));
`endif
          end
        end
      end
    end
  end

  initial begin : stim
    int n;
    int c0;
    int target;
    int fbefore;
    rstn = 1'b0;
    stdout_write_enable = 1'b0;
    stdout_write_data = 8'h00;

    // Reset state
    repeat (3) @(negedge clk);
    chk("reset_txd", 32'(txd), 32'(1));
    chk("reset_full", 32'(stdout_full), 32'(0));
    chk("reset_empty", 32'(stdout_empty), 32'(1));
    chk("reset_overflow", 32'(stdout_overflow), 32'(0));
    rstn = 1'b1;
    @(posedge clk);
    #1;

    // Single byte: start bit one edge after the write, empty one frame later
    drive(8'h55, 1'b1);
    chk("single_txd_before_pop", 32'(txd), 32'(1));
    chk("single_not_empty", 32'(stdout_empty), 32'(0));
    @(posedge clk);
    #1;
    chk("single_txd_falls", 32'(txd), 32'(0));
    wait_empty(n, 4 * FRAME);
    chk("single_empty_latency", 32'(n), 32'(FRAME));

    // Back-to-back frames with no idle gap
    starts.delete();
    drive(8'h41, 1'b1);
    drive(8'h42, 1'b1);
    chk("b2b_txd_falls", 32'(txd), 32'(0));
    wait_empty(n, 4 * FRAME);
    chk("b2b_total_cycles", 32'(n), 32'(2 * FRAME));
    chk("b2b_frame_count", 32'(starts.size()), 32'(2));
    if (starts.size() == 2) chk("b2b_start_gap", 32'(starts[1] - starts[0]), 32'(FRAME));

    // Fill and overflow: first byte pops at once, so five fit in a 4-deep FIFO
    for (int i = 0; i < 6; i++) begin
      drive(8'h10 + 8'(i), i < 5);
      if (i == 4) begin
        chk("fill_full_after_5th", 32'(stdout_full), 32'(1));
        chk("fill_no_overflow_yet", 32'(stdout_overflow), 32'(0));
      end
    end
    chk("fill_overflow_set", 32'(stdout_overflow), 32'(1));
    chk("fill_still_full", 32'(stdout_full), 32'(1));
    wait_empty(n, 8 * FRAME);
    chk("fill_drained", 32'(stdout_empty), 32'(1));
    chk("fill_overflow_sticky", 32'(stdout_overflow), 32'(1));
    chk("fill_full_clear", 32'(stdout_full), 32'(0));

    // Write while full on the exact edge where STOP pops
    do_reset();
    chk("reset2_overflow", 32'(stdout_overflow), 32'(0));
    drive(8'hA0, 1'b1);
    c0 = cyc;
    target = c0 + 1 + FRAME;
    for (int i = 1; i < 5; i++) drive(8'hA0 + 8'(i), 1'b1);
    while (cyc < target - 1) begin
      @(posedge clk);
      #1;
    end
    chk("pop_race_full_before", 32'(stdout_full), 32'(1));
    chk("pop_race_ovf_before", 32'(stdout_overflow), 32'(0));
    drive(8'hEE, 1'b0);
    chk("pop_race_ovf_set", 32'(stdout_overflow), 32'(1));
    chk("pop_race_count_dropped", 32'(stdout_full), 32'(0));
    wait_empty(n, 8 * FRAME);
    chk("pop_race_drained", 32'(stdout_empty), 32'(1));

    // Reset in the middle of DATA bit 3 of 0xA5 with two bytes queued
    do_reset();
    fbefore = frames_done;
    drive(8'hA5, 1'b0);
    c0 = cyc;
    drive(8'hB1, 1'b0);
    drive(8'hB2, 1'b0);
    target = c0 + 1 + 4 * CPB + 1;
    while (cyc < target) begin
      @(posedge clk);
      #1;
    end
    chk("midframe_bit3_low", 32'(txd), 32'(0));
    rstn = 1'b0;
    #1;
    chk("midframe_reset_txd", 32'(txd), 32'(1));
    chk("midframe_reset_empty", 32'(stdout_empty), 32'(1));
    chk("midframe_reset_full", 32'(stdout_full), 32'(0));
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    repeat (3 * FRAME) @(posedge clk);
    #1;
    chk("midframe_no_more_frames", 32'(frames_done), 32'(fbefore));
    chk("midframe_txd_idle", 32'(txd), 32'(1));
    chk("midframe_empty", 32'(stdout_empty), 32'(1));

`ifdef STDOUT_UART_TX_PARITY_EN
    // Parity: 0x07 has odd weight, 0x03 even
    starts.delete();
    drive(8'h07, 1'b1);
    drive(8'h03, 1'b1);
    wait_empty(n, 4 * FRAME);
    chk("parity_total_cycles", 32'(n), 32'(2 * FRAME));
    chk("parity_frame_count", 32'(starts.size()), 32'(2));
    if (starts.size() == 2) chk("parity_frame_len", 32'(starts[1] - starts[0]), 32'(11 * CPB));
`endif

    repeat (4) @(posedge clk);
    chk("scoreboard_empty", 32'(sb.size()), 32'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/stdout_uart_tx.md
Name: stdout_uart_tx

Overview:
- Transmit end of the core's STDOUT path. The core raises stdout_write_enable during a STDOUT instruction, and this block accepts the low byte of the rs1 value.
- Accepted bytes are buffered in a small FIFO and serialized onto a UART TXD line as 8N1, LSB first.
- Sits between the core's register-read stage and the board UART pin. It gives back-pressure status so the core can stall on full.

Parameters:
- CLK_PER_BIT, 868, clock cycles per UART bit (100 MHz / 115200). Legal range ≥ 2.
- FIFO_DEPTH, 16, byte entries in the FIFO. Must be a power of 2 and ≥ 2.

Ports:
- clk  input  1  system clock; all logic is on the rising edge.
- rstn  input  1  asynchronous active-low reset.
- stdout_write_enable  input  1  write strobe from the core, one byte per cycle when high.
- stdout_write_data  input  8  byte to send (rs1[7:0]).
- stdout_full  output  1  FIFO full; the core must stall a STDOUT instruction while high.
- stdout_empty  output  1  FIFO empty and serializer idle (all output drained).
- stdout_overflow  output  1  sticky flag: a write arrived while full. Cleared only by reset.
- txd  output  1  UART serial out; idles high.

Behaviour:
- Reset (rstn low, asynchronous):
  - txd=1, stdout_full=0, stdout_empty=1, stdout_overflow=0.
  - FIFO pointers, count, bit counter and baud counter all cleared; FSM forced to IDLE.
  - Reset asserted mid-frame aborts the frame immediately, with txd=1 from the reset edge. Any queued bytes are discarded.
- FIFO:
  - Read and write pointers are log2(FIFO_DEPTH) bits wide and wrap modulo FIFO_DEPTH. The count register is log2(FIFO_DEPTH)+1 bits.
  - stdout_full = (count == FIFO_DEPTH).
  - A write with stdout_full high is dropped and sets stdout_overflow on the next edge. This holds even if a pop happens in the same cycle, because full is evaluated on the registered count.
  - Simultaneous push and pop when not full: count stays unchanged and both pointers advance.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: txd=1. If count>0, pop the head byte into the shift register, reset the baud counter, go to START.
  - START: txd=0 for CLK_PER_BIT cycles, then go to DATA with bit index 0.
  - DATA: txd=shift[0] for CLK_PER_BIT cycles per bit, shifting right after each bit. After 8 bits go to STOP.
  - STOP: txd=1 for CLK_PER_BIT cycles. At its end, if count>0, pop and go directly to START with no idle gap; otherwise go to IDLE.
- Timing and latency:
  - A write sampled at edge N is in the FIFO after N. IDLE pops at edge N+1, so txd falls at edge N+1.
  - Frame length is exactly 10·CLK_PER_BIT cycles.
  - The baud counter counts 0..CLK_PER_BIT-1; a bit ends when the counter reaches CLK_PER_BIT-1.
- Outputs:
  - txd is driven from a register and never glitches.
  - stdout_empty = (count==0) && (state==IDLE).

Optional Feature:
- Macro: STDOUT_UART_TX_PARITY_EN.
- Defined:
  - Adds a PARITY state between DATA and STOP.
  - txd = XOR of the 8 data bits (even parity) for CLK_PER_BIT cycles.
  - Frame becomes 8E1, 11·CLK_PER_BIT cycles.
- Undefined: 8N1, 10·CLK_PER_BIT cycles, and no PARITY state is synthesized.

Test Plan:
- Single byte: CLK_PER_BIT=4, write 0x55 once. Required:
  - txd falls 1 cycle later.
  - Then 4-cycle bits 0 | 1,0,1,0,1,0,1,0 | 1 (start | data LSB first | stop).
  - stdout_empty returns to 1 after 40 cycles.
- Back-to-back: write 0x41, then 0x42 on consecutive cycles. Required: two frames with no idle cycle between the stop bit of 0x41 and the start bit of 0x42, 80 cycles total.
- Fill and overflow: FIFO_DEPTH=4, CLK_PER_BIT=4, write 6 bytes on consecutive cycles 0x10..0x15. Required:
  - The first byte is popped at once, so 0x10–0x14 are accepted.
  - stdout_full goes high after the 5th write, and 0x15 is dropped.
  - stdout_overflow=1 and stays 1 after the FIFO drains.
  - Output order is 0x10,0x11,0x12,0x13,0x14.
- Full with simultaneous pop: hold the FIFO full and write on the exact cycle STOP pops. Required: the write is dropped, overflow is set, and count becomes FIFO_DEPTH-1.
- Reset mid-frame: deassert rstn during DATA bit 3 of 0xA5 with 2 more bytes queued. Required:
  - txd=1, stdout_empty=1, stdout_full=0 asynchronously.
  - No further frames after rstn rises.
- Parity (macro defined): write 0x07, then 0x03. Required: parity bit 1 for 0x07 and 0 for 0x03, each frame 44 cycles at CLK_PER_BIT=4.
